// File: rtl/mux2_stim_sequencer.sv
// Clocked, restartable a/b/c stimulus source for Logic_mux2 that counts how many iterations returned y=1.
// Optional feature: define MUX2_STIM_LFSR_EN to replace the alternating pattern with an 8-bit LFSR sequence.
module mux2_stim_sequencer #(
    parameter int         ITERATIONS  = 10,
    parameter int         HOLD_CYCLES = 1,
    parameter logic [7:0] SEED        = 8'hA5
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic                               y_in,
    output logic                               a,
    output logic                               b,
    output logic                               c,
    output logic                               busy,
    output logic                               done,
    output logic [$clog2(ITERATIONS+1)-1:0]    iter_cnt,
    output logic [$clog2(ITERATIONS+1)-1:0]    y_ones
);

    localparam int CW = $clog2(ITERATIONS + 1);
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] ITER_LAST = CW'(ITERATIONS);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_DONE
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [HW-1:0] hold_cnt;
    logic [HW-1:0] hold_next;
    logic [CW-1:0] iter_next;
    logic [CW-1:0] ones_next;
    logic          a_next;
    logic          b_next;
    logic          c_next;
    logic          busy_next;
    logic          done_next;
    logic          last_hold;
    logic          last_iter;
    logic          load_run;
    logic          advance;
    logic [2:0]    first_pat;
    logic [2:0]    step_pat;

    assign last_hold = (hold_cnt == HOLD_LAST);
    assign last_iter = (iter_cnt == ITER_LAST);
    assign load_run  = (state != ST_DRIVE) && start;
    assign advance   = (state == ST_DRIVE) && last_hold && !last_iter;

`ifdef MUX2_STIM_LFSR_EN
    logic [7:0] lfsr;
    logic [7:0] lfsr_next;
    logic [7:0] lfsr_step;
    logic [7:0] seed_load;

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    assign seed_load = (SEED == 8'h00) ? 8'h01 : SEED;
    assign lfsr_step = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    assign first_pat = seed_load[2:0];
    assign step_pat  = lfsr_step[2:0];

    always_comb begin
        lfsr_next = lfsr;
        if (load_run) begin
            lfsr_next = seed_load;
        end else if (advance) begin
            lfsr_next = lfsr_step;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= 8'h01;
        end else begin
            lfsr <= lfsr_next;
        end
    end
`else
    logic seed_unused;

    // The upcoming iteration is even exactly when the current one is odd.
    assign first_pat   = 3'b100;
    assign step_pat    = iter_cnt[0] ? 3'b011 : 3'b100;
    assign seed_unused = ^SEED;
`endif

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_next = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (last_hold && last_iter) begin
                    state_next = ST_DONE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs; y_in is sampled only on the final hold cycle.
    always_comb begin
        hold_next = hold_cnt;
        iter_next = iter_cnt;
        ones_next = y_ones;
        a_next    = a;
        b_next    = b;
        c_next    = c;
        busy_next = busy;
        done_next = done;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    hold_next              = '0;
                    iter_next              = CW'(1);
                    ones_next              = '0;
                    {a_next, b_next, c_next} = first_pat;
                    busy_next              = 1'b1;
                    done_next              = 1'b0;
                end
            end
            ST_DRIVE: begin
                if (last_hold) begin
                    ones_next = y_ones + CW'(y_in);
                    if (last_iter) begin
                        {a_next, b_next, c_next} = 3'b000;
                        busy_next                = 1'b0;
                        done_next                = 1'b1;
                    end else begin
                        hold_next                = '0;
                        iter_next                = iter_cnt + CW'(1);
                        {a_next, b_next, c_next} = step_pat;
                    end
                end else begin
                    hold_next = hold_cnt + HW'(1);
                end
            end
            default: begin
                busy_next = 1'b0;
                done_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            hold_cnt <= '0;
            iter_cnt <= '0;
            y_ones   <= '0;
            a        <= 1'b0;
            b        <= 1'b0;
            c        <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_next;
            hold_cnt <= hold_next;
            iter_cnt <= iter_next;
            y_ones   <= ones_next;
            a        <= a_next;
            b        <= b_next;
            c        <= c_next;
            busy     <= busy_next;
            done     <= done_next;
        end
    end

endmodule

// File: tb/tb_mux2_stim_sequencer.sv
// Directed bench for mux2_stim_sequencer: one instance with defaults, one with HOLD_CYCLES=3.
// Expected patterns follow the alternating default, or the hand-computed LFSR list when MUX2_STIM_LFSR_EN is defined.
module tb_mux2_stim_sequencer;

    logic       clk;
    logic       rst;
    logic       start1;
    logic       start3;
    logic       y1;
    logic       y3;
    logic       a1, b1, c1, busy1, done1;
    logic       a3, b3, c3, busy3, done3;
    logic [3:0] iter_cnt1, y_ones1;
    logic [3:0] iter_cnt3, y_ones3;
    int         y_mode1;
    int         errors;
    int         checks;

    typedef struct {
        int y_mode;
        int exp_ones;
    } vec_t;

    vec_t       vecs [4];
    logic [2:0] exp_pat [1:10];
    int         ones_a;

    mux2_stim_sequencer #(.ITERATIONS(10), .HOLD_CYCLES(1), .SEED(8'hA5)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .y_in(y1),
        .a(a1), .b(b1), .c(c1), .busy(busy1), .done(done1),
        .iter_cnt(iter_cnt1), .y_ones(y_ones1)
    );

    mux2_stim_sequencer #(.ITERATIONS(10), .HOLD_CYCLES(3), .SEED(8'hA5)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .y_in(y3),
        .a(a3), .b(b3), .c(c3), .busy(busy3), .done(done3),
        .iter_cnt(iter_cnt3), .y_ones(y_ones3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // y feedback for the default instance: 0, 1, a or b.
    always_comb begin
        case (y_mode1)
            0:       y1 = 1'b0;
            1:       y1 = 1'b1;
            2:       y1 = a1;
            default: y1 = b1;
        endcase
    end

    task automatic applyStimulus(input logic r, input logic s1, input logic s3);
        rst    = r;
        start1 = s1;
        start3 = s3;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int it;
        int ph;
        int busy_cycles;

        errors  = 0;
        checks  = 0;
        y_mode1 = 0;
        y3      = 1'b0;
        rst     = 1'b1;
        start1  = 1'b0;
        start3  = 1'b0;

`ifdef MUX2_STIM_LFSR_EN
        exp_pat[1] = 3'b101; exp_pat[2] = 3'b010; exp_pat[3]  = 3'b101;
        exp_pat[4] = 3'b010; exp_pat[5] = 3'b100; exp_pat[6]  = 3'b001;
        exp_pat[7] = 3'b011; exp_pat[8] = 3'b111; exp_pat[9]  = 3'b110;
        exp_pat[10] = 3'b101;
        ones_a = 6;
        vecs[0] = '{y_mode: 1, exp_ones: 10};
        vecs[1] = '{y_mode: 0, exp_ones: 0};
        vecs[2] = '{y_mode: 2, exp_ones: 6};
        vecs[3] = '{y_mode: 3, exp_ones: 5};
`else
        for (int n = 1; n <= 10; n++) begin
            exp_pat[n] = (n % 2 == 1) ? 3'b100 : 3'b011;
        end
        ones_a = 5;
        vecs[0] = '{y_mode: 1, exp_ones: 10};
        vecs[1] = '{y_mode: 0, exp_ones: 0};
        vecs[2] = '{y_mode: 2, exp_ones: 5};
        vecs[3] = '{y_mode: 3, exp_ones: 5};
`endif

        $display("[TB] reset");
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("rst_abc1", {a1, b1, c1}, 0);
        checkOutput("rst_busy1", busy1, 0);
        checkOutput("rst_done1", done1, 0);
        checkOutput("rst_iter1", iter_cnt1, 0);
        checkOutput("rst_ones1", y_ones1, 0);
        checkOutput("rst_busy3", busy3, 0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("idle_busy1", busy1, 0);

        $display("[TB] table-driven runs");
        for (int v = 0; v < 4; v++) begin
            y_mode1 = vecs[v].y_mode;
            applyStimulus(1'b0, 1'b1, 1'b0);
            checkOutput($sformatf("v%0d_ones_cleared", v), y_ones1, 0);
            checkOutput($sformatf("v%0d_done_cleared", v), done1, 0);
            for (int i = 1; i <= 10; i++) begin
                checkOutput($sformatf("v%0d_it%0d_abc", v, i), {a1, b1, c1}, exp_pat[i]);
                checkOutput($sformatf("v%0d_it%0d_iter", v, i), iter_cnt1, i);
                checkOutput($sformatf("v%0d_it%0d_busy", v, i), busy1, 1);
                applyStimulus(1'b0, 1'b0, 1'b0);
            end
            checkOutput($sformatf("v%0d_end_done", v), done1, 1);
            checkOutput($sformatf("v%0d_end_busy", v), busy1, 0);
            checkOutput($sformatf("v%0d_end_abc", v), {a1, b1, c1}, 0);
            checkOutput($sformatf("v%0d_end_iter", v), iter_cnt1, 10);
            checkOutput($sformatf("v%0d_end_ones", v), y_ones1, vecs[v].exp_ones);
            applyStimulus(1'b0, 1'b0, 1'b0);
            applyStimulus(1'b0, 1'b0, 1'b0);
            checkOutput($sformatf("v%0d_hold_done", v), done1, 1);
            checkOutput($sformatf("v%0d_hold_ones", v), y_ones1, vecs[v].exp_ones);
        end

        $display("[TB] start while busy, reset mid-run");
        y_mode1 = 1;
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("busy_start_iter2", iter_cnt1, 2);
        checkOutput("busy_start_abc2", {a1, b1, c1}, exp_pat[2]);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("busy_start_iter3", iter_cnt1, 3);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("busy_start_iter4", iter_cnt1, 4);
        checkOutput("busy_start_ones", y_ones1, 3);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("abort_abc", {a1, b1, c1}, 0);
        checkOutput("abort_busy", busy1, 0);
        checkOutput("abort_done", done1, 0);
        checkOutput("abort_iter", iter_cnt1, 0);
        checkOutput("abort_ones", y_ones1, 0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("restart_iter", iter_cnt1, 1);
        checkOutput("restart_abc", {a1, b1, c1}, exp_pat[1]);
        checkOutput("restart_busy", busy1, 1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("rst_over_start_busy", busy1, 0);
        checkOutput("rst_over_start_iter", iter_cnt1, 0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("rst_over_start_idle", busy1, 0);

        $display("[TB] HOLD_CYCLES=3 with glitching y");
        applyStimulus(1'b0, 1'b0, 1'b1);
        busy_cycles = 0;
        for (int k = 0; k < 30; k++) begin
            it = k / 3 + 1;
            ph = k % 3;
            if (busy3) busy_cycles++;
            checkOutput($sformatf("h3_k%0d_abc", k), {a3, b3, c3}, exp_pat[it]);
            checkOutput($sformatf("h3_k%0d_iter", k), iter_cnt3, it);
            y3 = (ph < 2) ? 1'b1 : exp_pat[it][2];
            applyStimulus(1'b0, 1'b0, 1'b0);
        end
        y3 = 1'b0;
        checkOutput("h3_busy_cycles", busy_cycles, 30);
        checkOutput("h3_end_busy", busy3, 0);
        checkOutput("h3_end_done", done3, 1);
        checkOutput("h3_end_abc", {a3, b3, c3}, 0);
        checkOutput("h3_end_iter", iter_cnt3, 10);
        checkOutput("h3_end_ones", y_ones3, ones_a);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
